id_ex_stage: RTL and testbench

- ID/EX pipeline register plus execute-stage operand forwarding. Sits directly upstream of the execute ALU.
- Captures decoded operands and control each cycle. Resolves RAW hazards against the MEM and WB stages.
- Drives ALU srca/srcb and alucontrol, store data, branch target, and the control fields forwarded to EX/MEM.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/id_ex_stage_fwd_mux.sv | 45 ++++
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Types and constants shared by the ID/EX stage and its forwarding muxes.
//   XLEN, REGW   - default datapath width and register-index width
//   alu_op_t     - ALU operation encoding seen by the execute ALU
//   resultsrc_t  - writeback source select (bit 0 set marks a load)
//   ex_ctrl_t    - control bundle held in the E stage
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_t;

  typedef struct packed {
    logic       regwrite;
    resultsrc_t resultsrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    alu_op_t    alucontrol;
    logic       alusrc;
    logic       valid;
  } ex_ctrl_t;

  // All-zero control word: "add x0" that writes nothing and is not valid.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Selects the freshest value of one E-stage source register.
//   idx                              - source register index held in E
//   regval                           - register-file value captured in E
//   rd_m, regwrite_m, aluresult_m    - MEM-stage producer
//   rd_w, regwrite_w, result_w       - WB-stage producer
//   value                            - selected operand
// Build option: EX_FWD_EN. When undefined the mux passes regval through and
// the producer inputs are ignored (the hazard unit then stalls every RAW).
// ---------------------------------------------------------------------------
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] idx,
  input  logic [XLEN-1:0] regval,
  input  logic [REGW-1:0] rd_m,
  input  logic            regwrite_m,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [REGW-1:0] rd_w,
  input  logic            regwrite_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] value
);

`ifdef EX_FWD_EN
  always_comb begin
    // NOTE: default assigned first so every path drives value; no latch.
    value = regval;
    // MEM is checked first: it holds the younger instruction's result.
    // x0 is hard-wired zero, so a "write" to it must never be forwarded.
    if (regwrite_m && (rd_m != '0) && (rd_m == idx)) begin
      value = aluresult_m;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == idx)) begin
      value = result_w;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx, rd_m, regwrite_m, aluresult_m, rd_w, regwrite_w, result_w};
  assign value      = regval;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with execute-stage operand forwarding, directly
// upstream of the ALU.
//   clk, reset (sync, active-high)
//   stall_e / flush_e         - hold / bubble the E registers (flush wins)
//   *_d                       - decoded instruction fields and control
//   rd_m, regwrite_m, aluresult_m, rd_w, regwrite_w, result_w
//                             - live MEM/WB producers for forwarding
//   srca_e, srcb_e, alucontrol_e  - ALU inputs
//   writedata_e               - forwarded rs2 value (store data)
//   pctarget_e                - pc_e + immext_e, wraps modulo 2^XLEN
//   pc_e, rs1_e, rs2_e, rd_e, control *_e - fields passed on to EX/MEM and
//                               the hazard unit
// Build option: EX_FWD_EN enables MEM/WB forwarding (see fwd_mux).
// ---------------------------------------------------------------------------
module id_ex_stage
  import riscv_pkg::ex_ctrl_t, riscv_pkg::alu_op_t, riscv_pkg::resultsrc_t,
         riscv_pkg::EX_CTRL_BUBBLE;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = riscv_pkg::REGW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] immext_d,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_d,
  input  logic [2:0]      alucontrol_d,
  input  logic            alusrc_d,
  input  logic            regwrite_d,
  input  logic            memwrite_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [1:0]      resultsrc_d,
  input  logic [REGW-1:0] rd_m,
  input  logic            regwrite_m,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [REGW-1:0] rd_w,
  input  logic            regwrite_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] srca_e,
  output logic [XLEN-1:0] srcb_e,
  output logic [2:0]      alucontrol_e,
  output logic [XLEN-1:0] writedata_e,
  output logic [XLEN-1:0] pctarget_e,
  output logic [XLEN-1:0] pc_e,
  output logic [REGW-1:0] rs1_e,
  output logic [REGW-1:0] rs2_e,
  output logic [REGW-1:0] rd_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            valid_e,
  output logic [1:0]      resultsrc_e
);

  ex_ctrl_t        ctrl_d;
  ex_ctrl_t        ctrl_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] immext_e;

  assign ctrl_d = '{
    regwrite:   regwrite_d,
    resultsrc:  resultsrc_t'(resultsrc_d),
    memwrite:   memwrite_d,
    branch:     branch_d,
    jump:       jump_d,
    alucontrol: alu_op_t'(alucontrol_d),
    alusrc:     alusrc_d,
    valid:      valid_d
  };

  // Reset and flush both load an all-zero bubble; flush beats stall.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (reset || flush_e) begin
      ctrl_e   <= EX_CTRL_BUBBLE;
      pc_e     <= '0;
      rd1_e    <= '0;
      rd2_e    <= '0;
      immext_e <= '0;
      rs1_e    <= '0;
      rs2_e    <= '0;
      rd_e     <= '0;
    end else if (!stall_e) begin
      ctrl_e   <= ctrl_d;
      pc_e     <= pc_d;
      rd1_e    <= rd1_d;
      rd2_e    <= rd2_d;
      immext_e <= immext_d;
      rs1_e    <= rs1_d;
      rs2_e    <= rs2_d;
      rd_e     <= rd_d;
    end
  end

  // Forwarding looks at the live M/W buses every cycle, stalled or not.
  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
    .idx         (rs1_e),
    .regval      (rd1_e),
    .rd_m        (rd_m),
    .regwrite_m  (regwrite_m),
    .aluresult_m (aluresult_m),
    .rd_w        (rd_w),
    .regwrite_w  (regwrite_w),
    .result_w    (result_w),
    .value       (srca_e)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
    .idx         (rs2_e),
    .regval      (rd2_e),
    .rd_m        (rd_m),
    .regwrite_m  (regwrite_m),
    .aluresult_m (aluresult_m),
    .rd_w        (rd_w),
    .regwrite_w  (regwrite_w),
    .result_w    (result_w),
    .value       (writedata_e)
  );

  assign srcb_e       = ctrl_e.alusrc ? immext_e : writedata_e;
  assign pctarget_e   = pc_e + immext_e;
  assign alucontrol_e = ctrl_e.alucontrol;
  assign resultsrc_e  = ctrl_e.resultsrc;
  assign regwrite_e   = ctrl_e.regwrite;
  assign memwrite_e   = ctrl_e.memwrite;
  assign branch_e     = ctrl_e.branch;
  assign jump_e       = ctrl_e.jump;
  assign valid_e      = ctrl_e.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the stage. Follows EX_FWD_EN like the design.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;
`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, stall_e, flush_e, valid_d;
  logic [XLEN-1:0] pc_d, rd1_d, rd2_d, immext_d;
  logic [REGW-1:0] rs1_d, rs2_d, rd_d;
  logic [2:0]      alucontrol_d;
  logic            alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]      resultsrc_d;
  logic [REGW-1:0] rd_m, rd_w;
  logic            regwrite_m, regwrite_w;
  logic [XLEN-1:0] aluresult_m, result_w;
  logic [XLEN-1:0] srca_e, srcb_e, writedata_e, pctarget_e, pc_e;
  logic [2:0]      alucontrol_e;
  logic [REGW-1:0] rs1_e, rs2_e, rd_e;
  logic            regwrite_e, memwrite_e, branch_e, jump_e, valid_e;
  logic [1:0]      resultsrc_e;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .pc_d(pc_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .immext_d(immext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d), .regwrite_d(regwrite_d),
    .memwrite_d(memwrite_d), .branch_d(branch_d), .jump_d(jump_d),
    .resultsrc_d(resultsrc_d), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .aluresult_m(aluresult_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .result_w(result_w), .srca_e(srca_e), .srcb_e(srcb_e),
    .alucontrol_e(alucontrol_e), .writedata_e(writedata_e),
    .pctarget_e(pctarget_e), .pc_e(pc_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .branch_e(branch_e), .jump_e(jump_e), .valid_e(valid_e),
    .resultsrc_e(resultsrc_e)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  aluc;
    logic [1:0]  resultsrc;
    logic        alusrc, regwrite, memwrite, branch, jump, valid;
  } instr_t;

  instr_t m;
  bit     model_live = 1'b0;

  // What the E stage holds after each edge.
  always @(posedge clk) begin
    if (reset || flush_e) begin
      m = '{pc: 0, rd1: 0, rd2: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, aluc: 0,
            resultsrc: 0, alusrc: 0, regwrite: 0, memwrite: 0, branch: 0,
            jump: 0, valid: 0};
      if (reset) model_live = 1'b1;
    end else if (!stall_e) begin
      m = '{pc: pc_d, rd1: rd1_d, rd2: rd2_d, imm: immext_d, rs1: rs1_d,
            rs2: rs2_d, rd: rd_d, aluc: alucontrol_d, resultsrc: resultsrc_d,
            alusrc: alusrc_d, regwrite: regwrite_d, memwrite: memwrite_d,
            branch: branch_d, jump: jump_d, valid: valid_d};
    end
  end

  // Newest architectural value of register idx, given its stale read value.
  function automatic logic [31:0] newest(input logic [4:0] idx, input logic [31:0] stale);
    if (!FWD || idx == 5'd0) return stale;
    if (regwrite_m && rd_m == idx) return aluresult_m;
    if (regwrite_w && rd_w == idx) return result_w;
    return stale;
  endfunction

  logic [31:0] exp_a, exp_wd;

  always @(negedge clk) begin
    if (model_live) begin
      exp_a  = newest(m.rs1, m.rd1);
      exp_wd = newest(m.rs2, m.rd2);
      check("srca_e",       srca_e,       exp_a);
      check("writedata_e",  writedata_e,  exp_wd);
      check("srcb_e",       srcb_e,       m.alusrc ? m.imm : exp_wd);
      check("pctarget_e",   pctarget_e,   m.pc + m.imm);
      check("pc_e",         pc_e,         m.pc);
      check("rs1_e",        32'(rs1_e),   32'(m.rs1));
      check("rs2_e",        32'(rs2_e),   32'(m.rs2));
      check("rd_e",         32'(rd_e),    32'(m.rd));
      check("alucontrol_e", 32'(alucontrol_e), 32'(m.aluc));
      check("resultsrc_e",  32'(resultsrc_e),  32'(m.resultsrc));
      check("ctrl_e", {27'd0, regwrite_e, memwrite_e, branch_e, jump_e, valid_e},
            {27'd0, m.regwrite, m.memwrite, m.branch, m.jump, m.valid});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_d(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [2:0] op, input logic asrc);
    pc_d = pc; rd1_d = r1; rd2_d = r2; immext_d = imm;
    rs1_d = s1; rs2_d = s2; rd_d = d; alucontrol_d = op; alusrc_d = asrc;
    valid_d = 1'b1; regwrite_d = 1'b1; memwrite_d = 1'b0;
    branch_d = 1'b0; jump_d = 1'b0; resultsrc_d = 2'b00;
  endtask

  task automatic rand_d();
    pc_d = $urandom; rd1_d = $urandom; rd2_d = $urandom; immext_d = $urandom;
    rs1_d = REGW'($urandom_range(0, 3));
    rs2_d = REGW'($urandom_range(0, 3));
    rd_d  = REGW'($urandom_range(0, 3));
    alucontrol_d = 3'($urandom_range(0, 5));
    alusrc_d = 1'($urandom); valid_d = 1'($urandom); regwrite_d = 1'($urandom);
    memwrite_d = 1'($urandom); branch_d = 1'($urandom); jump_d = 1'($urandom);
    resultsrc_d = 2'($urandom_range(0, 2));
  endtask

  task automatic rand_mw();
    rd_m = REGW'($urandom_range(0, 3)); regwrite_m = 1'($urandom); aluresult_m = $urandom;
    rd_w = REGW'($urandom_range(0, 3)); regwrite_w = 1'($urandom); result_w = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rd_m = '0; regwrite_m = 1'b0; aluresult_m = '0;
    rd_w = '0; regwrite_w = 1'b0; result_w = '0;
    load_d(32'h1234, 32'h55, 32'h66, 32'h10, 5'd1, 5'd2, 5'd3, 3'b011, 1'b1);
    tick(); tick();
    check("reset srca_e",      srca_e,      32'h0);
    check("reset srcb_e",      srcb_e,      32'h0);
    check("reset pctarget_e",  pctarget_e,  32'h0);
    check("reset pc_e",        pc_e,        32'h0);
    check("reset valid_e",     32'(valid_e),    32'h0);
    check("reset regwrite_e",  32'(regwrite_e), 32'h0);
    reset = 1'b0;

    // Normal load.
    load_d(32'h100, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0);
    tick();
    check("load srca_e",       srca_e,       32'd5);
    check("load srcb_e",       srcb_e,       32'd7);
    check("load pctarget_e",   pctarget_e,   32'h120);
    check("load alucontrol_e", 32'(alucontrol_e), 32'h1);

    // MEM-over-WB priority, re-evaluated while stalled.
    load_d(32'h200, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 3'b000, 1'b0);
    tick();
    stall_e = 1'b1;
    rd_m = 5'd3; regwrite_m = 1'b1; aluresult_m = 32'hAA;
    rd_w = 5'd3; regwrite_w = 1'b1; result_w = 32'hBB;
    #1 check("prio mem srca_e", srca_e, FWD ? 32'hAA : 32'h11);
    regwrite_m = 1'b0;
    #1 check("prio wb srca_e",  srca_e, FWD ? 32'hBB : 32'h11);
    regwrite_w = 1'b0;
    #1 check("prio none srca_e", srca_e, 32'h11);
    stall_e = 1'b0;

    // x0 guard.
    rd_m = 5'd0; regwrite_m = 1'b1; aluresult_m = 32'hFF;
    load_d(32'h240, 32'h1, 32'h0, 32'h0, 5'd1, 5'd0, 5'd6, 3'b000, 1'b0);
    tick();
    check("x0 writedata_e", writedata_e, 32'h0);
    check("x0 srcb_e",      srcb_e,      32'h0);
    load_d(32'h244, 32'h1, 32'h0, 32'h4, 5'd1, 5'd0, 5'd6, 3'b000, 1'b1);
    tick();
    check("x0 imm srcb_e",  srcb_e,      32'h4);
    regwrite_m = 1'b0;

    // Stall for three cycles with changing decode inputs, then stall+flush.
    load_d(32'h300, 32'h31, 32'h32, 32'h8, 5'd6, 5'd7, 5'd8, 3'b010, 1'b0);
    tick();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      tick();
      check("stall pc_e",   pc_e,          32'h300);
      check("stall rd_e",   32'(rd_e),     32'd8);
      check("stall srca_e", srca_e,        32'h31);
      check("stall valid_e", 32'(valid_e), 32'h1);
    end
    flush_e = 1'b1;
    tick();
    check("flush valid_e",    32'(valid_e),    32'h0);
    check("flush regwrite_e", 32'(regwrite_e), 32'h0);
    check("flush memwrite_e", 32'(memwrite_e), 32'h0);
    check("flush rd_e",       32'(rd_e),       32'h0);
    flush_e = 1'b0; stall_e = 1'b0;

    // PC-target wrap.
    load_d(32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0);
    tick();
    check("wrap pctarget_e", pctarget_e, 32'h0000_0010);

    // Reset while stalled clears the stage.
    stall_e = 1'b1; reset = 1'b1;
    tick();
    check("reset-in-stall pc_e",    pc_e,          32'h0);
    check("reset-in-stall valid_e", 32'(valid_e),  32'h0);
    reset = 1'b0; stall_e = 1'b0;

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rand_d();
      rand_mw();
      reset   = ($urandom_range(0, 99) == 0);
      stall_e = ($urandom_range(0, 99) < 20);
      flush_e = ($urandom_range(0, 99) < 10);
      tick();
    end
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
